// File: rtl/prienc_pkg.sv
// Shared types and helpers for the multi-match priority iterator.
package prienc_pkg;

    // Upper bound on vector width accepted by the width-parameterised helpers.
    localparam int unsigned MaxWidth = 1024;

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } state_e;

    function automatic logic [MaxWidth-1:0] bit_reverse(input logic [MaxWidth-1:0] v,
                                                        input int unsigned          width);
        logic [MaxWidth-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i < width) r[i] = v[width-1-i];
        end
        return r;
    endfunction

    function automatic logic [MaxWidth-1:0] clear_mask(input int unsigned idx);
        logic [MaxWidth-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/prienc_iter_if.sv
// Match-vector input and index-beat output handshakes of the priority iterator.
interface prienc_iter_if #(
    parameter int unsigned IN_WIDTH = 128
) ();
    localparam int unsigned OUT_WIDTH = $clog2(IN_WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_req;
    logic                 abort;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_idx;
    logic                 out_last;
    logic                 out_none;

    modport master (
        output in_valid, in_req, abort, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none
    );

    modport slave (
        input  in_valid, in_req, abort, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none
    );
endinterface

// File: rtl/prienc_lsb.sv
// Combinational encoder: index of the lowest set bit (0 when none set).
module prienc_lsb #(
    parameter int unsigned WIDTH = 128
) (
    input  logic [WIDTH-1:0]         req_i,
    output logic [$clog2(WIDTH)-1:0] idx_o
);
    localparam int unsigned IdxW = $clog2(WIDTH);

    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IdxW'(i);
        end
    end
endmodule

// File: rtl/prienc_iter.sv
// Multi-match priority iterator: accepts a match vector and emits each set-bit index
// one beat per cycle in priority order, flagging the last beat and all-zero vectors.
module prienc_iter
    import prienc_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 128,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    prienc_iter_if.slave bus
);
    localparam int unsigned OUT_WIDTH = $clog2(IN_WIDTH);

    state_e               state_q, state_d;
    logic [IN_WIDTH-1:0]  pending_q, pending_d;
    logic                 zero_q, zero_d;

    logic [MaxWidth-1:0]  rev_full;
    logic [MaxWidth-1:0]  mask_full;
    logic [IN_WIDTH-1:0]  enc_in;
    logic [OUT_WIDTH-1:0] lsb_idx;
    logic [OUT_WIDTH-1:0] enc_idx;
    logic                 scan;
    logic                 last;
    logic                 fire;
    logic                 ready;

    // MSB-first reuses the LSB encoder on the reversed vector.
    always_comb begin
        rev_full = bit_reverse(MaxWidth'(pending_q), IN_WIDTH);
        enc_in   = MSB_FIRST ? rev_full[IN_WIDTH-1:0] : pending_q;
        enc_idx  = MSB_FIRST ? OUT_WIDTH'(IN_WIDTH - 1) - lsb_idx : lsb_idx;
    end

    prienc_lsb #(
        .WIDTH (IN_WIDTH)
    ) u_lsb (
        .req_i (enc_in),
        .idx_o (lsb_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = zero_q;
        mask_full = clear_mask(32'(bus.out_idx));
        if (bus.abort) begin
            state_d   = StIdle;
            pending_d = '0;
            zero_d    = 1'b0;
        end else if (bus.in_valid && ready) begin
            state_d   = StScan;
            pending_d = bus.in_req;
            zero_d    = (bus.in_req == '0);
        end else if (fire) begin
            if (last) begin
                state_d   = StIdle;
                pending_d = '0;
                zero_d    = 1'b0;
            end else begin
                pending_d = pending_q & ~mask_full[IN_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        scan          = (state_q == StScan);
        last          = scan && (zero_q || ((pending_q & (pending_q - 1'b1)) == '0));
        fire          = scan && bus.out_ready;
        ready         = !bus.abort && (!scan || (fire && last));
        bus.in_ready  = ready;
        bus.out_valid = scan;
        bus.out_idx   = (scan && !zero_q) ? enc_idx : '0;
        bus.out_last  = last;
        bus.out_none  = scan && zero_q;
    end
endmodule

// File: tb/tb_prienc_iter.sv
// Directed bench for prienc_iter: one LSB-first and one MSB-first instance, 128-bit vectors.
module tb_prienc_iter;
    localparam int unsigned W = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prienc_iter_if #(.IN_WIDTH(W)) if_l ();
    prienc_iter_if #(.IN_WIDTH(W)) if_m ();

    prienc_iter #(.IN_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(if_l));
    prienc_iter #(.IN_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(if_m));

    // Beat observation packed as {valid, idx[6:0], last, none}.
    function automatic logic [9:0] beat(input logic v, input logic [6:0] i, input logic l,
                                        input logic n);
        return {v, i, l, n};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_l.in_valid = 1'b0; if_l.in_req = '0; if_l.abort = 1'b0; if_l.out_ready = 1'b1;
        if_m.in_valid = 1'b0; if_m.in_req = '0; if_m.abort = 1'b0; if_m.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        cyc(); if_l.in_valid = 1'b1; if_l.in_req = 128'h8421;
        cyc(); if_l.in_valid = 1'b0; if_l.out_ready = 1'b0;
        cyc(); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            got = beat(if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.out_none);
            checks++;
            if (got !== 10'h0) begin
                errors++; $display("FAIL reset_outputs cyc %0d got %h exp %h", i, got, 10'h0);
            end
        end
        rst = 1'b0; if_l.out_ready = 1'b1;
        cyc(); #1;
        checks++;
        if (if_l.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", if_l.in_ready);
        end
        checks++;
        if (if_l.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_beats got %b exp 0", if_l.out_valid);
        end
    endtask

    task automatic test_lsb_order();
        logic [9:0] got, exp;
        int idxs[4] = '{0, 5, 10, 15};
        cyc(); if_l.in_valid = 1'b1; if_l.in_req = 128'h8421; #1;
        checks++;
        if (if_l.in_ready !== 1'b1) begin
            errors++; $display("FAIL lsb_accept_ready got %b exp 1", if_l.in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(); if_l.in_valid = 1'b0; #1;
            got = beat(if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.out_none);
            exp = (k < 4) ? beat(1'b1, 7'(idxs[k]), k == 3, 1'b0) : 10'h0;
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL lsb_order beat %0d got %h exp %h", k, got, exp);
            end
        end
    endtask

    task automatic test_msb_back_to_back();
        logic [9:0] got, exp;
        int idxs[6] = '{15, 10, 5, 0, 1, 0};
        cyc(); if_m.in_valid = 1'b1; if_m.in_req = 128'h8421;
        for (int k = 0; k < 7; k++) begin
            cyc();
            if_m.in_valid = (k < 4); if_m.in_req = (k < 4) ? 128'h3 : '0;
            #1;
            got = beat(if_m.out_valid, if_m.out_idx, if_m.out_last, if_m.out_none);
            exp = (k < 6) ? beat(1'b1, 7'(idxs[k]), k == 3 || k == 5, 1'b0) : 10'h0;
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL msb_order beat %0d got %h exp %h", k, got, exp);
            end
            if (k < 4) begin
                checks++;
                if (if_m.in_ready !== (k == 3)) begin
                    errors++;
                    $display("FAIL msb_b2b_ready beat %0d got %b exp %b", k, if_m.in_ready, k == 3);
                end
            end
        end
    endtask

    task automatic test_zero_full();
        logic [9:0] got, exp;
        cyc(); if_l.in_valid = 1'b1; if_l.in_req = '0;
        for (int k = 0; k < 2; k++) begin
            cyc(); if_l.in_valid = 1'b0; #1;
            got = beat(if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.out_none);
            exp = (k == 0) ? beat(1'b1, 7'd0, 1'b1, 1'b1) : 10'h0;
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL zero_vec beat %0d got %h exp %h", k, got, exp);
            end
        end
        if_l.in_valid = 1'b1; if_l.in_req = '1;
        for (int k = 0; k < int'(W) + 1; k++) begin
            cyc(); if_l.in_valid = 1'b0; #1;
            got = beat(if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.out_none);
            exp = (k < int'(W)) ? beat(1'b1, 7'(k), k == int'(W) - 1, 1'b0) : 10'h0;
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL full_vec beat %0d got %h exp %h", k, got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] got, exp;
        logic rdy[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        cyc(); if_l.in_valid = 1'b1; if_l.in_req = 128'h90;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if_l.in_valid = 1'b0; if_l.in_req = 128'hFF;
            if_l.out_ready = (k < 4) ? rdy[k] : 1'b1;
            #1;
            got = beat(if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.out_none);
            exp = (k == 0) ? beat(1'b1, 7'd4, 1'b0, 1'b0) :
                  (k < 4)  ? beat(1'b1, 7'd7, 1'b1, 1'b0) : 10'h0;
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL backpressure beat %0d got %h exp %h", k, got, exp);
            end
            if (k == 1 || k == 3) begin
                checks++;
                if (if_l.in_ready !== (k == 3)) begin
                    errors++;
                    $display("FAIL bp_ready beat %0d got %b exp %b", k, if_l.in_ready, k == 3);
                end
            end
        end
        if_l.in_req = '0;
    endtask

    task automatic test_abort();
        logic [9:0] got;
        cyc(); if_l.in_valid = 1'b1; if_l.in_req = 128'hF0;
        cyc(); if_l.in_valid = 1'b0; #1;
        got = beat(if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.out_none);
        checks++;
        if (got !== beat(1'b1, 7'd4, 1'b0, 1'b0)) begin
            errors++; $display("FAIL abort_beat4 got %h exp %h", got, beat(1'b1, 7'd4, 1'b0, 1'b0));
        end
        cyc(); if_l.abort = 1'b1; if_l.in_valid = 1'b1; if_l.in_req = 128'h1; #1;
        got = beat(if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.out_none);
        checks++;
        if (got !== beat(1'b1, 7'd5, 1'b0, 1'b0)) begin
            errors++; $display("FAIL abort_beat5 got %h exp %h", got, beat(1'b1, 7'd5, 1'b0, 1'b0));
        end
        checks++;
        if (if_l.in_ready !== 1'b0) begin
            errors++; $display("FAIL abort_in_ready got %b exp 0", if_l.in_ready);
        end
        cyc(); if_l.abort = 1'b0; #1;
        checks++;
        if (if_l.out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_valid got %b exp 0", if_l.out_valid);
        end
        checks++;
        if (if_l.in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_ready_after got %b exp 1", if_l.in_ready);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(); if_l.in_valid = 1'b0; #1;
            got = beat(if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.out_none);
            checks++;
            if (got !== ((k == 0) ? beat(1'b1, 7'd0, 1'b1, 1'b0) : 10'h0)) begin
                errors++; $display("FAIL abort_next_vec beat %0d got %h", k, got);
            end
        end
        // Abort while idle leaves the iterator idle.
        if_l.abort = 1'b1;
        cyc(); if_l.abort = 1'b0; #1;
        checks++;
        if ({if_l.out_valid, if_l.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL abort_idle got %b%b exp 01", if_l.out_valid, if_l.in_ready);
        end
    endtask

    initial begin
        idle_inputs();
        cyc(); cyc();
        rst = 1'b0;
        test_reset();
        idle_inputs();
        test_lsb_order();
        test_msb_back_to_back();
        idle_inputs();
        test_zero_full();
        test_backpressure();
        idle_inputs();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
